intersection_scheduler: RTL and testbench

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

---
 rtl/shared_pkg.sv | 33 +++
 rtl/intersection_scheduler_phase_timer.sv | 22 ++
 rtl/intersection_scheduler.sv | 105 ++++++++++
 tb/tb_intersection_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types for the intersection scheduler: light colours, sensor levels,
// FSM phases and default timing parameters.
package shared_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colors;

  typedef enum logic {
    NO_CARS = 1'b0,
    CARS    = 1'b1
  } sensor_state_e;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_TO_EW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_TO_NS = 3'd5
  } phase_e;

  localparam int unsigned DEF_MIN_GREEN   = 4;
  localparam int unsigned DEF_MAX_GREEN   = 10;
  localparam int unsigned DEF_YELLOW_CYC  = 2;
  localparam int unsigned DEF_ALL_RED_CYC = 1;

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Per-phase cycle counter: zero in the first cycle of a phase, counts up and
// saturates at its maximum so long greens never wrap.
module phase_timer
  import shared_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (clear)            r_cnt <= '0;
    else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  assign count = r_cnt;

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach traffic light controller: demand-latched green extension with
// minimum/maximum green, fixed yellow and all-red clearance.
module intersection_scheduler
  import shared_pkg::*;
#(
  parameter int unsigned MIN_GREEN   = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN   = DEF_MAX_GREEN,
  parameter int unsigned YELLOW_CYC  = DEF_YELLOW_CYC,
  parameter int unsigned ALL_RED_CYC = DEF_ALL_RED_CYC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  sensor_state_e ns_sensor,
  input  sensor_state_e ew_sensor,
  output colors         ns_light,
  output colors         ew_light,
  output logic          ns_wait,
  output logic          ew_wait
);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(ALL_RED_CYC - 1);

  phase_e           r_state;
  phase_e           w_next;
  logic [CNT_W-1:0] w_cnt;
  logic             w_clear;
  logic             r_ns_wait;
  logic             r_ew_wait;
  logic             w_enter_ns;
  logic             w_enter_ew;
  logic             w_ns_done;
  logic             w_ew_done;

  phase_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .count (w_cnt)
  );

  // Max-green force uses >= so a request latched after the counter has
  // already run past MAX_GREEN-1 (saturated) is still served next cycle.
  assign w_ns_done = r_ew_wait &&
                     (((w_cnt >= MIN_LAST) && (ns_sensor == NO_CARS)) || (w_cnt >= MAX_LAST));
  assign w_ew_done = r_ns_wait &&
                     (((w_cnt >= MIN_LAST) && (ew_sensor == NO_CARS)) || (w_cnt >= MAX_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RED_TO_NS;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      NS_GREEN:  if (w_ns_done)         w_next = NS_YELLOW;
      NS_YELLOW: if (w_cnt == YEL_LAST) w_next = RED_TO_EW;
      RED_TO_EW: if (w_cnt == RED_LAST) w_next = EW_GREEN;
      EW_GREEN:  if (w_ew_done)         w_next = EW_YELLOW;
      EW_YELLOW: if (w_cnt == YEL_LAST) w_next = RED_TO_NS;
      RED_TO_NS: if (w_cnt == RED_LAST) w_next = NS_GREEN;
      default:                          w_next = RED_TO_NS;
    endcase
  end

  assign w_clear    = (w_next != r_state);
  assign w_enter_ns = (w_next == NS_GREEN) && (r_state != NS_GREEN);
  assign w_enter_ew = (w_next == EW_GREEN) && (r_state != EW_GREEN);

  // Entering the approach's own green clears its flag even if the sensor
  // is still asserting demand in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ns_wait <= 1'b0;
      r_ew_wait <= 1'b0;
    end else begin
      if (w_enter_ns)                                       r_ns_wait <= 1'b0;
      else if ((ns_sensor == CARS) && (r_state != NS_GREEN)) r_ns_wait <= 1'b1;
      if (w_enter_ew)                                       r_ew_wait <= 1'b0;
      else if ((ew_sensor == CARS) && (r_state != EW_GREEN)) r_ew_wait <= 1'b1;
    end
  end

  always_comb begin
    ns_light = RED;
    ew_light = RED;
    case (r_state)
      NS_GREEN:  ns_light = GREEN;
      NS_YELLOW: ns_light = YELLOW;
      EW_GREEN:  ew_light = GREEN;
      EW_YELLOW: ew_light = YELLOW;
      default: begin
        ns_light = RED;
        ew_light = RED;
      end
    endcase
  end

  assign ns_wait = r_ns_wait;
  assign ew_wait = r_ew_wait;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed table-driven bench for intersection_scheduler with default timing.
module tb_intersection_scheduler;
  import shared_pkg::*;

  logic          clk;
  logic          rst_n;
  sensor_state_e ns_sensor;
  sensor_state_e ew_sensor;
  colors         ns_light;
  colors         ew_light;
  logic          ns_wait;
  logic          ew_wait;

  int checks = 0;
  int errors = 0;

  intersection_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ns_sensor (ns_sensor),
    .ew_sensor (ew_sensor),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .ns_wait   (ns_wait),
    .ew_wait   (ew_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            rst;
    sensor_state_e ns_s;
    sensor_state_e ew_s;
    colors         ns_l;
    colors         ew_l;
    logic          nw;
    logic          ew;
    int            scen;
  } vec_t;

  vec_t tbl[$];
  int   cur_scen;

  task automatic add(input int n, input bit rst, input sensor_state_e ns_s,
                     input sensor_state_e ew_s, input colors ns_l, input colors ew_l,
                     input logic nw, input logic ewf);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.rst  = rst && (k == 0);
      v.ns_s = ns_s;
      v.ew_s = ew_s;
      v.ns_l = ns_l;
      v.ew_l = ew_l;
      v.nw   = nw;
      v.ew   = ewf;
      v.scen = cur_scen;
      tbl.push_back(v);
    end
  endtask

  task automatic chk(input string name, input int idx, input colors ns_l,
                     input colors ew_l, input logic nw, input logic ewf);
    checks++;
    if ({ns_light, ew_light, ns_wait, ew_wait} !== {ns_l, ew_l, nw, ewf}) begin
      errors++;
      $display("FAIL %s row %0d: got ns=%s ew=%s nw=%b ew=%b, want ns=%s ew=%s nw=%b ew=%b",
               name, idx, ns_light.name(), ew_light.name(), ns_wait, ew_wait,
               ns_l.name(), ew_l.name(), nw, ewf);
    end
  endtask

  // Hold reset for two cycles, check the reset state, release at a falling edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    ns_sensor = NO_CARS;
    ew_sensor = NO_CARS;
    repeat (2) @(negedge clk);
    chk("reset_state", 0, RED, RED, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Safety and colour-sequence monitor, sampled just after each falling edge.
  colors p_ns = RED;
  colors p_ew = RED;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      p_ns = RED;
      p_ew = RED;
    end else begin
      checks++;
      if (ns_light != RED && ew_light != RED) begin
        errors++;
        $display("FAIL conflict: ns=%s ew=%s both non-RED", ns_light.name(), ew_light.name());
      end
      checks++;
      if ((p_ns == GREEN && ns_light == RED) || (p_ns == YELLOW && ns_light == GREEN) ||
          (p_ns == RED && ns_light == YELLOW) || (p_ew == GREEN && ew_light == RED) ||
          (p_ew == YELLOW && ew_light == GREEN) || (p_ew == RED && ew_light == YELLOW)) begin
        errors++;
        $display("FAIL sequence: ns %s->%s ew %s->%s", p_ns.name(), ns_light.name(),
                 p_ew.name(), ew_light.name());
      end
      p_ns = ns_light;
      p_ew = ew_light;
    end
  end

  initial begin
    rst_n     = 1'b0;
    ns_sensor = NO_CARS;
    ew_sensor = NO_CARS;

    // Scenario 1: no demand, NS green held
    cur_scen = 1;
    add(1,  1, NO_CARS, NO_CARS, RED,   RED, 0, 0);
    add(50, 0, NO_CARS, NO_CARS, GREEN, RED, 0, 0);

    // Scenario 2: EW demand only
    cur_scen = 2;
    add(1,  1, NO_CARS, CARS, RED,    RED,   0, 0);
    add(4,  0, NO_CARS, CARS, GREEN,  RED,   0, 1);
    add(2,  0, NO_CARS, CARS, YELLOW, RED,   0, 1);
    add(1,  0, NO_CARS, CARS, RED,    RED,   0, 1);
    add(30, 0, NO_CARS, CARS, RED,    GREEN, 0, 0);

    // Scenario 3: both demanding, two 26-cycle periods
    cur_scen = 3;
    add(1, 1, CARS, CARS, RED, RED, 0, 0);
    for (int p = 0; p < 2; p++) begin
      add(10, 0, CARS, CARS, GREEN,  RED,    0, 1);
      add(1,  0, CARS, CARS, YELLOW, RED,    0, 1);
      add(1,  0, CARS, CARS, YELLOW, RED,    1, 1);
      add(1,  0, CARS, CARS, RED,    RED,    1, 1);
      add(10, 0, CARS, CARS, RED,    GREEN,  1, 0);
      add(1,  0, CARS, CARS, RED,    YELLOW, 1, 0);
      add(1,  0, CARS, CARS, RED,    YELLOW, 1, 1);
      add(1,  0, CARS, CARS, RED,    RED,    1, 1);
    end
    add(2, 0, CARS, CARS, GREEN, RED, 0, 1);

    // Scenario 4: single-cycle EW pulse at NS_GREEN cnt 1
    cur_scen = 4;
    add(1, 1, CARS, NO_CARS, RED,    RED,    0, 0);
    add(1, 0, CARS, NO_CARS, GREEN,  RED,    0, 0);
    add(1, 0, CARS, CARS,    GREEN,  RED,    0, 0);
    add(8, 0, CARS, NO_CARS, GREEN,  RED,    0, 1);
    add(1, 0, CARS, NO_CARS, YELLOW, RED,    0, 1);
    add(1, 0, CARS, NO_CARS, YELLOW, RED,    1, 1);
    add(1, 0, CARS, NO_CARS, RED,    RED,    1, 1);
    add(4, 0, CARS, NO_CARS, RED,    GREEN,  1, 0);
    add(2, 0, CARS, NO_CARS, RED,    YELLOW, 1, 0);
    add(1, 0, CARS, NO_CARS, RED,    RED,    1, 0);
    add(6, 0, CARS, NO_CARS, GREEN,  RED,    0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      ns_sensor = tbl[i].ns_s;
      ew_sensor = tbl[i].ew_s;
      chk($sformatf("scen%0d", tbl[i].scen), i, tbl[i].ns_l, tbl[i].ew_l, tbl[i].nw, tbl[i].ew);
      @(negedge clk);
    end

    // Scenario 5: asynchronous reset in the second yellow cycle
    do_reset();
    ns_sensor = NO_CARS;
    ew_sensor = CARS;
    repeat (6) @(negedge clk);
    chk("s5_yellow1", 0, YELLOW, RED, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("s5_async_rst", 1, RED, RED, 1'b0, 1'b0);
    @(negedge clk);
    chk("s5_held", 2, RED, RED, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("s5_restart_red", 3, RED, RED, 1'b0, 1'b0);
    @(negedge clk);
    chk("s5_restart_green", 4, GREEN, RED, 1'b0, 1'b1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
